// File: rtl/cmp_stat_monitor.sv
// Statistics monitor for registered comparator results: per-outcome counts, run tracking, alert and sticky err.
// Optional irq output (alert rising-edge pulse) is enabled by defining CMP_STAT_MONITOR_IRQ_EN.
module cmp_stat_monitor #(
  parameter int CNT_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             ls,
  input  logic             eq,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] ls_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] cur_streak,
  output logic [CNT_W-1:0] max_streak,
  output logic [1:0]       streak_kind,
  output logic             alert,
  output logic             err
`ifdef CMP_STAT_MONITOR_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, ALERT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(STREAK_TH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       kind_nxt;
  logic [CNT_W-1:0] streak_nxt;
  logic [CNT_W-1:0] max_nxt;
  logic [1:0]       sample_kind;
  logic             one_hot;
  logic             sample_ok;
  logic             malformed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // in_valid qualifies gt/ls/eq; there is no back-pressure, every valid sample is consumed in the cycle it is presented.
  assign one_hot     = (gt ^ ls ^ eq) & ~(gt & ls & eq);
  assign sample_ok   = in_valid & one_hot;
  assign malformed   = in_valid & ~one_hot;
  assign sample_kind = gt ? 2'b01 : (ls ? 2'b10 : 2'b11);

  always_comb begin
    state_nxt  = state;
    kind_nxt   = streak_kind;
    streak_nxt = cur_streak;
    max_nxt    = max_streak;
    if (sample_ok) begin
      if (state == IDLE || streak_kind != sample_kind) begin
        kind_nxt   = sample_kind;
        streak_nxt = ONE;
      end else begin
        streak_nxt = sat_inc(cur_streak);
      end
      state_nxt = (streak_nxt >= TH) ? ALERT : RUN;
      max_nxt   = (streak_nxt > max_streak) ? streak_nxt : max_streak;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      streak_kind <= 2'b00;
      cur_streak  <= '0;
      max_streak  <= '0;
    end else if (clr) begin
      state       <= IDLE;
      streak_kind <= 2'b00;
      cur_streak  <= '0;
      max_streak  <= '0;
    end else begin
      state       <= state_nxt;
      streak_kind <= kind_nxt;
      cur_streak  <= streak_nxt;
      max_streak  <= max_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gt_cnt <= '0;
      ls_cnt <= '0;
      eq_cnt <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      gt_cnt <= '0;
      ls_cnt <= '0;
      eq_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (malformed) err <= 1'b1;
      if (sample_ok && gt) gt_cnt <= sat_inc(gt_cnt);
      if (sample_ok && ls) ls_cnt <= sat_inc(ls_cnt);
      if (sample_ok && eq) eq_cnt <= sat_inc(eq_cnt);
    end
  end

  assign alert = (state == ALERT);

`ifdef CMP_STAT_MONITOR_IRQ_EN
  // Pulse only on the transition into ALERT, never while it persists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     irq <= 1'b0;
    else if (clr) irq <= 1'b0;
    else          irq <= sample_ok && (state != ALERT) && (state_nxt == ALERT);
  end
`endif

endmodule

// File: doc/cmp_stat_monitor.md
Name: cmp_stat_monitor

Overview:
- Downstream consumer of the registered comparator outputs (gt, ls, eq).
- Qualifies each result with in_valid and keeps saturating per-outcome counts.
- Tracks the current and longest run of identical outcomes, and raises alert when a run reaches STREAK_TH.
- Flags malformed result vectors via a sticky err bit; feeds status/debug logic.

Parameters:
CNT_W, 8, width of all counters and streak registers
STREAK_TH, 4, run length (1..2^CNT_W-1) at which alert asserts

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  gt/ls/eq valid this cycle
gt  input  1  comparator result a>b
ls  input  1  comparator result a<b
eq  input  1  comparator result a==b
clr  input  1  synchronous clear of all statistics
gt_cnt  output  CNT_W  count of valid gt samples
ls_cnt  output  CNT_W  count of valid ls samples
eq_cnt  output  CNT_W  count of valid eq samples
cur_streak  output  CNT_W  length of current identical run
max_streak  output  CNT_W  longest run since reset/clr
streak_kind  output  2  kind of current run: 00 none, 01 gt, 10 ls, 11 eq
alert  output  1  current run length >= STREAK_TH
err  output  1  sticky: malformed sample seen

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM in IDLE. Release is synchronous to clk.
- All outputs are registered. A sample accepted at edge N is reflected in the outputs after edge N, with 1-cycle latency.
- Sample well-formed: in_valid=1 and exactly one of gt/ls/eq = 1.
- Sample malformed: in_valid=1 and zero or more than one of gt/ls/eq set. Effect: err<=1 (sticky); counters, streaks and FSM unchanged.
- in_valid=0: nothing changes; gt/ls/eq are don't-care.
- Counters: the matching counter increments by 1 per well-formed sample and saturates at 2^CNT_W-1 (no wrap).
- FSM states:
  - IDLE: streak_kind=00, cur_streak=0.
  - RUN: 1 <= cur_streak < STREAK_TH.
  - ALERT: cur_streak >= STREAK_TH; alert=1 only in ALERT.
- Transitions, on each well-formed sample of kind K:
  - IDLE -> RUN: kind<=K, cur_streak<=1. If STREAK_TH==1, go directly to ALERT.
  - RUN/ALERT, K == kind: cur_streak+1, saturating. Enter ALERT when the new value >= STREAK_TH.
  - RUN/ALERT, K != kind: kind<=K, cur_streak<=1, state RUN (ALERT if STREAK_TH==1). alert drops the cycle after the differing sample.
- max_streak <= max(max_streak, new cur_streak), updated in the same cycle as cur_streak; it saturates with it.
- clr=1: all counters, streaks and err <= 0; FSM <= IDLE. clr has priority over a simultaneous in_valid sample, which is dropped.
- Reset asserted mid-run: immediate return to reset values; no partial update.

Optional Feature:
- Macro: CMP_STAT_MONITOR_IRQ_EN.
- Defined: adds output irq (1 bit, reset 0). irq is a single-cycle pulse in the cycle alert rises (FSM entering ALERT from IDLE or RUN). No pulse while ALERT persists; clr or reset forces irq=0.
- Not defined: the irq port and its logic are absent; everything else is identical.

Test Plan:
- Reset check: hold rst=0 with random inputs and clk running -> all outputs 0. Release rst, drive in_valid=0 for 5 cycles -> outputs stay 0.
- Run to alert: with STREAK_TH=4, send eq,eq,eq,eq,gt (in_valid=1 each cycle).
  - After the 4th eq: eq_cnt=4, cur_streak=4, streak_kind=11, alert=1, max_streak=4.
  - After gt: alert=0, streak_kind=01, cur_streak=1, gt_cnt=1, max_streak=4.
- Malformed samples: send gt=1,ls=1 with in_valid=1 -> err=1, counters unchanged. Send {0,0,0} -> err stays 1. A following well-formed ls gives ls_cnt=1 and err=1 (sticky).
- Saturation: with CNT_W=4, send 20 consecutive ls -> ls_cnt=15, cur_streak=15, max_streak=15, alert=1, no wrap.
- Clear: assert clr together with in_valid=1, gt=1 while counts are nonzero -> next cycle all outputs 0 and gt_cnt=0 (sample dropped).
- Irq, CMP_STAT_MONITOR_IRQ_EN defined: with STREAK_TH=2, send gt,gt,gt -> irq=1 for exactly one cycle after the 2nd gt and 0 after the 3rd. Assert rst=0 mid-run -> all outputs 0 immediately.
